// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 16-bit pipeline.
// It consumes the EX/MEM register outputs and fills the MEM/WB register.
// Non-memory instructions pass through with a 1-cycle latency.
// Loads and stores run a req/ack transaction on the data-memory port. The
// pipeline stalls until the memory acks or the access times out.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   valid_in .. mem_to_reg_in EX/MEM slot contents
//   stall_out                 upstream holds its inputs (combinational from state)
//   dmem_*                    data-memory req/ack port
//   valid_out .. bus_err_out  MEM/WB slot; valid_out/bus_err_out are 1-cycle pulses
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [15:0] alu_result_in,
    input  logic [15:0] rs2_data_in,
    input  logic [3:0]  rd_in,
    input  logic        reg_write_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        mem_to_reg_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic        valid_out,
    output logic [15:0] wb_data_out,
    output logic [3:0]  rd_out,
    output logic        reg_write_out,
    output logic        bus_err_out
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       rd_q;
    logic             reg_write_q;
    logic             mem_to_reg_q;
    logic             accept;
    logic             mem_op;

    assign stall_out = (state == ACCESS);
    assign accept    = valid_in && !stall_out;
    assign mem_op    = mem_read_in || mem_write_in;

    // Stage FSM; the pulse outputs default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            rd_q          <= '0;
            reg_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            valid_out     <= 1'b0;
            wb_data_out   <= '0;
            rd_out        <= '0;
            reg_write_out <= 1'b0;
            bus_err_out   <= 1'b0;
        end else begin
            valid_out     <= 1'b0;
            reg_write_out <= 1'b0;
            bus_err_out   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !mem_op) begin
                        valid_out     <= 1'b1;
                        wb_data_out   <= alu_result_in;
                        rd_out        <= rd_in;
                        reg_write_out <= reg_write_in;
                    end else if (accept) begin
                        // A read+write combination is a store, since we follows mem_write_in.
                        rd_q         <= rd_in;
                        reg_write_q  <= reg_write_in;
                        mem_to_reg_q <= mem_to_reg_in;
                        dmem_req     <= 1'b1;
                        dmem_we      <= mem_write_in;
                        dmem_addr    <= alu_result_in;
                        dmem_wdata   <= rs2_data_in;
                        cnt          <= '0;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    // An ack takes priority over a timeout in the same cycle.
                    if (dmem_ack) begin
                        dmem_req      <= 1'b0;
                        valid_out     <= 1'b1;
                        wb_data_out   <= mem_to_reg_q ? dmem_rdata : dmem_addr;
                        rd_out        <= rd_q;
                        reg_write_out <= reg_write_q;
                        state         <= IDLE;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        dmem_req    <= 1'b0;
                        valid_out   <= 1'b1;
                        bus_err_out <= 1'b1;
                        wb_data_out <= '0;
                        rd_out      <= rd_q;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed plus randomized checks of mem_stage with TIMEOUT_CYCLES=4.
// Expected results come from transaction-level rules:
//   - an ALU op completes one cycle after it is accepted;
//   - a memory op completes at the ack if the ack arrives within TIMEOUT cycles;
//   - otherwise the op ends with a bus error.
module tb_mem_stage;
    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [15:0] alu_result_in;
    logic [15:0] rs2_data_in;
    logic [3:0]  rd_in;
    logic        reg_write_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        mem_to_reg_in;
    logic        stall_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic        valid_out;
    logic [15:0] wb_data_out;
    logic [3:0]  rd_out;
    logic        reg_write_out;
    logic        bus_err_out;

    int total = 0;
    int bad   = 0;

    // Model of the MEM/WB values that must hold between pulses.
    logic [15:0] exp_wb;
    logic [3:0]  exp_rd;
    logic        rd_known;

    mem_stage #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .alu_result_in(alu_result_in),
        .rs2_data_in(rs2_data_in), .rd_in(rd_in), .reg_write_in(reg_write_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_to_reg_in(mem_to_reg_in), .stall_out(stall_out), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .valid_out(valid_out),
        .wb_data_out(wb_data_out), .rd_out(rd_out), .reg_write_out(reg_write_out),
        .bus_err_out(bus_err_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        valid_in      = 1'b0;
        alu_result_in = '0;
        rs2_data_in   = '0;
        rd_in         = '0;
        reg_write_in  = 1'b0;
        mem_read_in   = 1'b0;
        mem_write_in  = 1'b0;
        mem_to_reg_in = 1'b0;
    endtask

    task automatic alu_issue(input logic [15:0] alu, input logic [3:0] rd, input logic rw);
        valid_in      = 1'b1;
        alu_result_in = alu;
        rs2_data_in   = 16'($urandom);
        rd_in         = rd;
        reg_write_in  = rw;
        mem_read_in   = 1'b0;
        mem_write_in  = 1'b0;
        mem_to_reg_in = 1'($urandom);
    endtask

    // An ALU op presented now must complete at the next edge.
    task automatic alu_check(input logic [15:0] alu, input logic [3:0] rd, input logic rw);
        chk("alu_pre_stall", stall_out, 1'b0);
        tick();
        chk("alu_valid", valid_out, 1'b1);
        chk("alu_wb", wb_data_out, alu);
        chk("alu_rd", rd_out, rd);
        chk("alu_rw", reg_write_out, rw);
        chk("alu_err", bus_err_out, 1'b0);
        chk("alu_stall", stall_out, 1'b0);
        exp_wb   = alu;
        exp_rd   = rd;
        rd_known = 1'b1;
        clear_inputs();
    endtask

    task automatic do_alu(input logic [15:0] alu, input logic [3:0] rd, input logic rw);
        alu_issue(alu, rd, rw);
        alu_check(alu, rd, rw);
    endtask

    // Idle cycle: pulses low, MEM/WB values and the port address held, ack ignored.
    task automatic idle(input logic ack);
        logic [15:0] addr_before;
        addr_before = dmem_addr;
        clear_inputs();
        dmem_ack   = ack;
        dmem_rdata = 16'($urandom);
        tick();
        dmem_ack = 1'b0;
        chk("idle_valid", valid_out, 1'b0);
        chk("idle_rw", reg_write_out, 1'b0);
        chk("idle_err", bus_err_out, 1'b0);
        chk("idle_stall", stall_out, 1'b0);
        chk("idle_req", dmem_req, 1'b0);
        chk("idle_wb_hold", wb_data_out, exp_wb);
        chk("idle_addr_hold", dmem_addr, addr_before);
        if (rd_known) chk("idle_rd_hold", rd_out, exp_rd);
    endtask

    // Memory op acked ack_delay cycles after the request; ack_delay > TMO means no ack.
    // With pend set, an ALU op waits on the inputs during the access.
    task automatic do_mem(input logic rd_en, input logic wr_en, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [3:0] rd, input logic rw,
                          input logic m2r, input int ack_delay, input logic [15:0] rdata,
                          input logic pend, input logic [15:0] p_alu, input logic [3:0] p_rd,
                          input logic p_rw);
        logic done;
        logic exp_we;
        exp_we        = wr_en;
        valid_in      = 1'b1;
        alu_result_in = addr;
        rs2_data_in   = wdata;
        rd_in         = rd;
        reg_write_in  = rw;
        mem_read_in   = rd_en;
        mem_write_in  = wr_en;
        mem_to_reg_in = m2r;
        chk("mem_pre_stall", stall_out, 1'b0);
        tick();
        chk("mem_req", dmem_req, 1'b1);
        chk("mem_we", dmem_we, exp_we);
        chk("mem_addr", dmem_addr, addr);
        chk("mem_wdata", dmem_wdata, wdata);
        chk("mem_stall", stall_out, 1'b1);
        chk("mem_valid_low", valid_out, 1'b0);
        if (pend) alu_issue(p_alu, p_rd, p_rw);
        else begin
            clear_inputs();
            // Changed inputs while stalled must not reach the memory port.
            alu_result_in = 16'($urandom);
            rs2_data_in   = 16'($urandom);
        end
        done = 1'b0;
        for (int k = 1; k <= int'(TMO) && !done; k++) begin
            dmem_ack   = (k == ack_delay);
            dmem_rdata = (k == ack_delay) ? rdata : 16'($urandom);
            tick();
            dmem_ack = 1'b0;
            done     = (k == ack_delay) || (k == int'(TMO));
            if (!done) begin
                chk("acc_req", dmem_req, 1'b1);
                chk("acc_we", dmem_we, exp_we);
                chk("acc_addr", dmem_addr, addr);
                chk("acc_wdata", dmem_wdata, wdata);
                chk("acc_stall", stall_out, 1'b1);
                chk("acc_valid_low", valid_out, 1'b0);
            end
        end
        chk("done_req", dmem_req, 1'b0);
        chk("done_valid", valid_out, 1'b1);
        chk("done_stall", stall_out, 1'b0);
        if (ack_delay <= int'(TMO)) begin
            chk("done_err", bus_err_out, 1'b0);
            chk("done_wb", wb_data_out, m2r ? rdata : addr);
            chk("done_rd", rd_out, rd);
            chk("done_rw", reg_write_out, rw);
            exp_wb   = m2r ? rdata : addr;
            exp_rd   = rd;
            rd_known = 1'b1;
        end else begin
            chk("tmo_err", bus_err_out, 1'b1);
            chk("tmo_wb", wb_data_out, 16'h0000);
            chk("tmo_rw", reg_write_out, 1'b0);
            exp_wb   = 16'h0000;
            rd_known = 1'b0;
        end
        if (!pend) clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        exp_wb     = '0;
        exp_rd     = '0;
        rd_known   = 1'b1;
        tick();
        tick();
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_stall", stall_out, 1'b0);
        chk("rst_wb", wb_data_out, 16'h0000);
        rst = 1'b0;
        idle(1'b1);

        // ALU pass-through.
        do_alu(16'h1234, 4'd3, 1'b1);
        idle(1'b0);
        // Load, ack two cycles after the request.
        do_mem(1'b1, 1'b0, 16'h0040, 16'h0000, 4'd5, 1'b1, 1'b1, 2, 16'hBEEF,
               1'b0, 16'h0, 4'd0, 1'b0);
        idle(1'b0);
        // Store, reg_write off.
        do_mem(1'b0, 1'b1, 16'h0100, 16'hA5A5, 4'd0, 1'b0, 1'b0, 3, 16'h5555,
               1'b0, 16'h0, 4'd0, 1'b0);
        idle(1'b0);
        // Timeout without any ack.
        do_mem(1'b1, 1'b0, 16'h0200, 16'h0000, 4'd7, 1'b1, 1'b1, 99, 16'h0,
               1'b0, 16'h0, 4'd0, 1'b0);
        idle(1'b0);
        // Ack in the timeout cycle wins.
        do_mem(1'b1, 1'b0, 16'h0300, 16'h0000, 4'd8, 1'b1, 1'b1, int'(TMO), 16'hCAFE,
               1'b0, 16'h0, 4'd0, 1'b0);
        // Read+write together behaves as a store.
        do_mem(1'b1, 1'b1, 16'h0400, 16'h1111, 4'd9, 1'b1, 1'b0, 1, 16'h2222,
               1'b0, 16'h0, 4'd0, 1'b0);
        // Load then ALU back-to-back, immediate ack.
        do_mem(1'b1, 1'b0, 16'h0500, 16'h0000, 4'd1, 1'b1, 1'b1, 1, 16'h7777,
               1'b1, 16'h4321, 4'd2, 1'b1);
        alu_check(16'h4321, 4'd2, 1'b1);
        idle(1'b0);

        // Reset in the middle of an access.
        valid_in      = 1'b1;
        alu_result_in = 16'h0600;
        rs2_data_in   = 16'h3333;
        mem_write_in  = 1'b1;
        tick();
        clear_inputs();
        tick();
        chk("mid_req_before", dmem_req, 1'b1);
        rst = 1'b1;
        tick();
        chk("midrst_req", dmem_req, 1'b0);
        chk("midrst_stall", stall_out, 1'b0);
        chk("midrst_valid", valid_out, 1'b0);
        chk("midrst_we", dmem_we, 1'b0);
        chk("midrst_addr", dmem_addr, 16'h0000);
        chk("midrst_wb", wb_data_out, 16'h0000);
        chk("midrst_rd", rd_out, 4'd0);
        tick();
        rst      = 1'b0;
        exp_wb   = '0;
        exp_rd   = '0;
        rd_known = 1'b1;
        idle(1'b0);

        // Randomized instruction stream.
        for (int i = 0; i < 60; i++) begin
            int          op;
            logic [15:0] a;
            logic [3:0]  r;
            logic        w;
            logic        pend;
            logic [15:0] pa;
            logic [3:0]  pr;
            logic        pw;
            op   = int'($urandom_range(0, 3));
            a    = 16'($urandom);
            r    = 4'($urandom);
            w    = 1'($urandom);
            pend = 1'($urandom);
            pa   = 16'($urandom);
            pr   = 4'($urandom);
            pw   = 1'($urandom);
            if (op == 0) begin
                do_alu(a, r, w);
            end else begin
                do_mem(op != 2, op != 1, a, 16'($urandom), r, w, 1'($urandom),
                       int'($urandom_range(1, 6)), 16'($urandom), pend, pa, pr, pw);
                if (pend) alu_check(pa, pr, pw);
            end
            if ($urandom_range(0, 1) == 1) idle(1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
